// File: rtl/mxv_pkg.sv
// Shared types and constant helpers for the matrix-vector row MAC datapath.
package mxv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_HOLD,
    ST_DONE
  } state_e;

  // Smallest r with 2**r >= value; returns 0 for value <= 1.
  function automatic int CeilLog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << r) < 64'(value)) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mxv_index_counter.sv
// Wrap-around index counter: counts 0..MAX_VALUE-1, flag marks the terminal index.
module mxv_index_counter #(
  parameter int MAX_VALUE = 4,
  parameter int WIDTH     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             flag
);

  logic [WIDTH-1:0] count_q;

  assign count = count_q;
  assign flag  = (count_q == WIDTH'(MAX_VALUE - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= flag ? '0 : count_q + 1'b1;
    end
  end

endmodule

// File: rtl/mxv_row_mac.sv
// Row-wise multiply-accumulate: folds N_COLS products per row into a dot product
// and hands each row result downstream over a valid/ready interface.
module mxv_row_mac
  import mxv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_COLS = 4,
  parameter int N_ROWS = 4,
  parameter int ACC_W  = 20,
  localparam int COL_W = (CeilLog2(N_COLS) < 1) ? 1 : CeilLog2(N_COLS),
  localparam int ROW_W = (CeilLog2(N_ROWS) < 1) ? 1 : CeilLog2(N_ROWS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] mat_data,
  input  logic signed [DATA_W-1:0] vec_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_data,
  output logic [ROW_W-1:0]         out_row,
  output logic                     busy,
  output logic                     done
);

  localparam int PROD_W = 2 * DATA_W;

  state_e                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [ACC_W-1:0]   out_data_q, out_data_d;
  logic [ROW_W-1:0]          out_row_q, out_row_d;

  logic                      accept;
  logic                      xfer;
  logic                      start_ok;
  logic [COL_W-1:0]          col;
  logic                      col_last;
  logic [ROW_W-1:0]          row;
  logic                      row_last;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   acc_sum;

  // Handshake outputs decode straight from the state register, so neither
  // depends combinationally on the opposite side of its channel.
  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_HOLD);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;

  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;
  assign start_ok = start && (state_q == ST_IDLE);

  assign prod     = PROD_W'(mat_data) * PROD_W'(vec_data);
  assign prod_ext = ACC_W'(prod);
  assign acc_sum  = acc_q + prod_ext;

  mxv_index_counter #(
    .MAX_VALUE (N_COLS),
    .WIDTH     (COL_W)
  ) u_col_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (start_ok),
    .enable (accept),
    .count  (col),
    .flag   (col_last)
  );

  mxv_index_counter #(
    .MAX_VALUE (N_ROWS),
    .WIDTH     (ROW_W)
  ) u_row_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (start_ok),
    .enable (xfer),
    .count  (row),
    .flag   (row_last)
  );

  // NOTE: every always_comb target gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    out_row_d  = out_row_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d   = '0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          if (col_last) begin
            out_data_d = acc_sum;
            out_row_d  = row;
            state_d    = ST_HOLD;
          end else begin
            acc_d = acc_sum;
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          acc_d   = '0;
          state_d = row_last ? ST_DONE : ST_ACCUM;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      out_data_q <= '0;
      out_row_q  <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      out_row_q  <= out_row_d;
    end
  end

endmodule

// File: tb/tb_mxv_row_mac.sv
// Scoreboard bench for mxv_row_mac: expected row results are queued as rows are fed
// and compared when the DUT transfers them.
`timescale 1ns/1ps
module tb_mxv_row_mac;

  localparam int DATA_W = 8;
  localparam int N_COLS = 4;
  localparam int N_ROWS = 4;
  localparam int ACC_W  = 20;
  localparam int ROW_W  = 2;

  typedef struct packed {
    logic [ACC_W-1:0] data;
    logic [ROW_W-1:0] row;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] mat_data;
  logic [DATA_W-1:0] vec_data;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic [ROW_W-1:0]  out_row;
  logic              busy;
  logic              done;

  exp_t sb[$];
  int   n_cmp    = 0;
  int   n_err    = 0;
  int   done_cnt = 0;
  int   acc_cnt  = 0;

  int m_pos[N_COLS] = '{1, 2, 3, 4};
  int m_neg[N_COLS] = '{-1, -2, -3, -4};
  int v_std[N_COLS] = '{5, 6, 7, 8};
  int m_min[N_COLS] = '{-128, -128, -128, -128};
  int m_max[N_COLS] = '{127, 127, 127, 127};

  mxv_row_mac #(
    .DATA_W (DATA_W),
    .N_COLS (N_COLS),
    .N_ROWS (N_ROWS),
    .ACC_W  (ACC_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mat_data  (mat_data),
    .vec_data  (vec_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [ACC_W-1:0] dot(input int m[N_COLS], input int v[N_COLS]);
    int s;
    s = 0;
    for (int i = 0; i < N_COLS; i++) s += m[i] * v[i];
    return ACC_W'(s);
  endfunction

  // Monitor samples 1ns after the falling edge, after the driver has settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        if (in_valid && in_ready) acc_cnt++;
        if (done) done_cnt++;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_out", 32'(sb.size()), 1);
          end else begin
            e = sb.pop_front();
            check("out_data", 32'(out_data), 32'(e.data));
            check("out_row", 32'(out_row), 32'(e.row));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input int a, input int b);
    int n;
    n = 0;
    mat_data = DATA_W'(a);
    vec_data = DATA_W'(b);
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) begin
      check("in_ready_timeout", 32'(in_ready), 1);
    end else begin
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic feed_row(input int m[N_COLS], input int v[N_COLS], input bit gap, input int r);
    sb.push_back('{data: dot(m, v), row: ROW_W'(r)});
    for (int i = 0; i < N_COLS; i++) begin
      send(m[i], v[i]);
      if (gap && i < N_COLS - 1) @(negedge clk);
    end
    check("latency_valid", 32'(out_valid), 1);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("busy_end", 32'(busy), 0);
  endtask

  initial begin
    int snap;
    reset     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    mat_data  = '0;
    vec_data  = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_row", 32'(out_row), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Plain operation, continuous input, downstream always ready.
    do_start();
    check("busy_after_start", 32'(busy), 1);
    for (int r = 0; r < N_ROWS; r++) feed_row(m_pos, v_std, 1'b0, r);
    wait_idle();
    check("done_count_a", 32'(done_cnt), 1);

    // Negative, extreme values, downstream stall and gapped input.
    do_start();
    out_ready = 1'b0;
    feed_row(m_neg, v_std, 1'b0, 0);
    snap     = acc_cnt;
    in_valid = 1'b1;
    mat_data = 8'h11;
    vec_data = 8'h22;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 1);
      check("stall_data", 32'(out_data), 32'(dot(m_neg, v_std)));
      check("stall_row", 32'(out_row), 0);
      check("stall_in_ready", 32'(in_ready), 0);
    end
    check("stall_no_accept", 32'(acc_cnt), 32'(snap));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    feed_row(m_min, m_min, 1'b0, 1);
    feed_row(m_max, m_min, 1'b1, 2);
    feed_row(m_pos, v_std, 1'b1, 3);
    wait_idle();
    check("done_count_b", 32'(done_cnt), 2);
    check("sb_empty_b", 32'(sb.size()), 0);

    // Reset in the middle of row 2 discards the operation.
    do_start();
    feed_row(m_pos, v_std, 1'b0, 0);
    feed_row(m_neg, v_std, 1'b0, 1);
    send(9, 9);
    send(3, 3);
    reset = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 0);
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_out_data", 32'(out_data), 0);
    check("mid_rst_out_row", 32'(out_row), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_no_done", 32'(done_cnt), 2);
    check("mid_rst_idle", 32'(busy), 0);

    // start with a pair present in IDLE, then start again inside a row.
    start    = 1'b1;
    in_valid = 1'b1;
    mat_data = 8'd99;
    vec_data = 8'd99;
    #1;
    check("idle_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    feed_row(m_pos, v_std, 1'b0, 0);
    sb.push_back('{data: dot(m_neg, v_std), row: ROW_W'(1)});
    send(m_neg[0], v_std[0]);
    send(m_neg[1], v_std[1]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send(m_neg[2], v_std[2]);
    send(m_neg[3], v_std[3]);
    check("restart_latency_valid", 32'(out_valid), 1);
    feed_row(m_min, m_min, 1'b0, 2);
    feed_row(m_max, m_min, 1'b0, 3);
    wait_idle();
    check("done_count_d", 32'(done_cnt), 3);
    check("sb_empty_end", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
